// File: rtl/rr_hold_arb_if.sv
// rr_hold_arb_if: request/grant bundle between four masters and the arbiter.
//
// Signals:
//   req   [3:0] level-sensitive request vector, bit i = requester i
//   grant [3:0] registered one-hot grant, all-zero when idle
//   busy        registered, high whenever a grant bit is set
//   owner [1:0] registered index of the current (or most recent) owner
//
// Modports:
//   master : the requesting side drives req and observes the grant outputs
//   slave  : the arbiter samples req and drives grant/busy/owner
interface rr_hold_arb_if;
    logic [3:0] req;
    logic [3:0] grant;
    logic       busy;
    logic [1:0] owner;

    modport master (
        output req,
        input  grant,
        input  busy,
        input  owner
    );

    modport slave (
        input  req,
        output grant,
        output busy,
        output owner
    );
endinterface

// File: rtl/rr_hold_arb.sv
// rr_hold_arb: four-requester round-robin arbiter with burst hold.
//
// The current owner keeps its grant while its request stays high, for at most
// MAX_HOLD consecutive cycles. On release (request dropped or hold expired) the
// grant passes at the same edge to the next requester found by scanning from
// owner+1, wrapping around and including the old owner, so an expired sole
// requester is simply re-granted. All outputs are registered; there is no
// combinational path from req to grant.
//
// Parameters:
//   MAX_HOLD : maximum consecutive grant cycles per tenure, 1..2^CNT_W-1
//   CNT_W    : width of the hold counter
//
// Ports:
//   clk   : system clock, all state updates on the rising edge
//   reset : synchronous, active-high reset
//   bus   : slave side of rr_hold_arb_if (req in; grant, busy, owner out)
module rr_hold_arb #(
    parameter int unsigned MAX_HOLD = 8,
    parameter int unsigned CNT_W    = 4
) (
    input logic          clk,
    input logic          reset,
    rr_hold_arb_if.slave bus
);

    localparam logic [CNT_W-1:0] MaxHold = CNT_W'(MAX_HOLD);
    localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

    typedef enum logic [0:0] {
        StIdle,
        StOwned
    } state_e;

    state_e           state_q, state_d;
    logic [3:0]       grant_q, grant_d;
    logic             busy_q, busy_d;
    logic [1:0]       owner_q, owner_d;
    logic [1:0]       last_q, last_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;

    // Search start: when idle, one past the last owner; when owned, one past
    // the current owner (which becomes the new last pointer on release).
    logic [1:0] search_start;
    logic [1:0] cand;
    logic       win_found;
    logic [1:0] win_idx;
    logic       owner_req;
    logic       hold_expired;

    always_comb begin
        search_start = (state_q == StIdle) ? last_q + 2'd1 : owner_q + 2'd1;
    end

    // First set request bit at or after search_start, wrapping mod 4.
    always_comb begin
        win_found = 1'b0;
        win_idx   = search_start;
        cand      = search_start;
        for (int i = 0; i < 4; i++) begin
            cand = search_start + 2'(i);
            if (!win_found && bus.req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        owner_req    = bus.req[owner_q];
        // >= rather than == keeps the release decision safe even if the
        // counter were ever somehow past the limit.
        hold_expired = (hold_cnt_q >= MaxHold);
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        busy_d     = busy_q;
        owner_d    = owner_q;
        last_d     = last_q;
        hold_cnt_d = hold_cnt_q;

        unique case (state_q)
            StIdle: begin
                if (win_found) begin
                    state_d    = StOwned;
                    grant_d    = 4'b0001 << win_idx;
                    busy_d     = 1'b1;
                    owner_d    = win_idx;
                    hold_cnt_d = CntOne;
                end else begin
                    grant_d = 4'b0000;
                    busy_d  = 1'b0;
                end
            end

            StOwned: begin
                if (owner_req && !hold_expired) begin
                    hold_cnt_d = hold_cnt_q + CntOne;
                end else begin
                    last_d = owner_q;
                    if (win_found) begin
                        // Back-to-back handover, possibly to the same owner.
                        grant_d    = 4'b0001 << win_idx;
                        busy_d     = 1'b1;
                        owner_d    = win_idx;
                        hold_cnt_d = CntOne;
                    end else begin
                        // owner keeps its value so it still names the last owner.
                        state_d    = StIdle;
                        grant_d    = 4'b0000;
                        busy_d     = 1'b0;
                        hold_cnt_d = '0;
                    end
                end
            end

            default: begin
                state_d    = StIdle;
                grant_d    = 4'b0000;
                busy_d     = 1'b0;
                hold_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            grant_q    <= 4'b0000;
            busy_q     <= 1'b0;
            owner_q    <= 2'd0;
            last_q     <= 2'd3;  // requester 0 has top priority after reset
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            busy_q     <= busy_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    assign bus.grant = grant_q;
    assign bus.busy  = busy_q;
    assign bus.owner = owner_q;

    // Structural invariants of the registered outputs.
    grant_onehot0 : assert property (@(posedge clk) disable iff (reset)
        $onehot0(grant_q));
    grant_busy_match : assert property (@(posedge clk) disable iff (reset)
        ((grant_q != 4'b0000) == busy_q));
    grant_owner_match : assert property (@(posedge clk) disable iff (reset)
        busy_q |-> grant_q[owner_q]);
    hold_bounded : assert property (@(posedge clk) disable iff (reset)
        hold_cnt_q <= MaxHold);
    busy_state_match : assert property (@(posedge clk) disable iff (reset)
        busy_q == (state_q == StOwned));

endmodule
